// File: rtl/pipelined_controller_pkg.sv
// Shared control definitions for the MIPS pipeline: opcodes, ALU codes, branch types and the
// control bundle that travels from ID through WB.
package mips_ctrl_pkg;

    localparam int ALU_W = 6;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_SLTI   = 6'b001010;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;

    localparam logic [4:0] RT_BLTZ = 5'b00000;
    localparam logic [4:0] RT_BGEZ = 5'b00001;

    localparam logic [ALU_W-1:0] ALU_ADD = 6'b100000;
    localparam logic [ALU_W-1:0] ALU_SUB = 6'b100010;
    localparam logic [ALU_W-1:0] ALU_AND = 6'b100100;
    localparam logic [ALU_W-1:0] ALU_OR  = 6'b100101;
    localparam logic [ALU_W-1:0] ALU_SLT = 6'b101010;

    typedef enum logic [2:0] {
        BR_NONE,
        BR_EQ,
        BR_NE,
        BR_LEZ,
        BR_GTZ,
        BR_LTZ,
        BR_GEZ
    } br_type_e;

    typedef struct packed {
        logic             reg_dst;
        logic             alu_src;
        logic [ALU_W-1:0] alu_ctrl;
        logic             mem_read;
        logic             mem_write;
        logic             reg_write;
        logic             mem_to_reg;
        br_type_e         br_type;
    } ctrl_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic mem_to_reg;
    } mem_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

    localparam ctrl_t CTRL_NOP = '{
        reg_dst:    1'b0,
        alu_src:    1'b0,
        alu_ctrl:   ALU_ADD,
        mem_read:   1'b0,
        mem_write:  1'b0,
        reg_write:  1'b0,
        mem_to_reg: 1'b0,
        br_type:    BR_NONE
    };

    // Instructions whose rt field is a source operand rather than a destination.
    function automatic logic reads_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
    endfunction

    function automatic logic br_taken(input br_type_e t, input logic zero, input logic neg);
        case (t)
            BR_EQ:   return zero;
            BR_NE:   return !zero;
            BR_LEZ:  return neg | zero;
            BR_GTZ:  return !neg & !zero;
            BR_LTZ:  return neg;
            BR_GEZ:  return !neg;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pipelined_controller_if.sv
// Instruction, ALU flags and staged control outputs exchanged between the datapath and the
// pipelined controller.
interface pipelined_controller_if #(
    parameter int ALU_CTRL_W = 6
);
    logic [31:0]           Instruction;
    logic                  ExZero;
    logic                  ExNeg;
    logic                  ExRegDst;
    logic                  ExALUSrc;
    logic [ALU_CTRL_W-1:0] ExALUControl;
    logic                  MemRead;
    logic                  MemWrite;
    logic                  WbRegWrite;
    logic                  WbMemtoReg;
    logic                  PCSrc;
    logic                  Stall;
    logic                  Flush;

    modport master (
        output Instruction, ExZero, ExNeg,
        input  ExRegDst, ExALUSrc, ExALUControl, MemRead, MemWrite,
               WbRegWrite, WbMemtoReg, PCSrc, Stall, Flush
    );

    modport slave (
        input  Instruction, ExZero, ExNeg,
        output ExRegDst, ExALUSrc, ExALUControl, MemRead, MemWrite,
               WbRegWrite, WbMemtoReg, PCSrc, Stall, Flush
    );
endinterface

// File: rtl/pipelined_controller_ctrl_decoder.sv
// Purely combinational instruction-to-control-bundle decode, zero latency; unknown opcodes,
// unknown REGIMM rt codes and the all-zero word decode to the NOP bundle.
module ctrl_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o
);
    logic [5:0] op;
    logic [4:0] rt;
    logic [5:0] funct;

    assign op    = instr_i[31:26];
    assign rt    = instr_i[20:16];
    assign funct = instr_i[5:0];

    always_comb begin
        ctrl_o = CTRL_NOP;
        case (op)
            OP_RTYPE: begin
                if (instr_i != 32'h0) begin
                    ctrl_o.reg_dst   = 1'b1;
                    ctrl_o.reg_write = 1'b1;
                    ctrl_o.alu_ctrl  = funct;
                end
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.reg_write = 1'b1;
                case (op)
                    OP_ANDI: ctrl_o.alu_ctrl = ALU_AND;
                    OP_ORI:  ctrl_o.alu_ctrl = ALU_OR;
                    OP_SLTI: ctrl_o.alu_ctrl = ALU_SLT;
                    default: ctrl_o.alu_ctrl = ALU_ADD;
                endcase
            end
            OP_LW: begin
                ctrl_o.alu_src    = 1'b1;
                ctrl_o.mem_read   = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_write  = 1'b1;
            end
            OP_SW: begin
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            OP_BEQ: begin
                ctrl_o.alu_ctrl = ALU_SUB;
                ctrl_o.br_type  = BR_EQ;
            end
            OP_BNE: begin
                ctrl_o.alu_ctrl = ALU_SUB;
                ctrl_o.br_type  = BR_NE;
            end
            OP_BLEZ: begin
                ctrl_o.alu_ctrl = ALU_SUB;
                ctrl_o.br_type  = BR_LEZ;
            end
            OP_BGTZ: begin
                ctrl_o.alu_ctrl = ALU_SUB;
                ctrl_o.br_type  = BR_GTZ;
            end
            OP_REGIMM: begin
                // rt is an opcode extension here, not a register operand.
                if (rt == RT_BLTZ) begin
                    ctrl_o.alu_ctrl = ALU_SUB;
                    ctrl_o.br_type  = BR_LTZ;
                end else if (rt == RT_BGEZ) begin
                    ctrl_o.alu_ctrl = ALU_SUB;
                    ctrl_o.br_type  = BR_GEZ;
                end
            end
            default: ctrl_o = CTRL_NOP;
        endcase
    end

endmodule

// File: rtl/pipelined_controller.sv
// Pipelined MIPS control: ID decode, ID/EX -> EX/MEM -> MEM/WB control registers (Ex* +1, Mem* +2,
// Wb* +3 cycles), EX branch resolution with flush, and load-use stall when HAZARD_DETECT_EN is defined.
module pipelined_controller
    import mips_ctrl_pkg::*;
#(
    parameter int   ALU_CTRL_W   = 6,
    parameter int   REG_ADDR_W   = 5,
    parameter logic RESET_PC_SRC = 1'b0
)(
    input  logic                  Clk,
    input  logic                  Rst,
    pipelined_controller_if.slave bus
);
    ctrl_t     id_ctrl;
    ctrl_t     idex_q, idex_d;
    mem_ctrl_t exmem_q, exmem_d;
    wb_ctrl_t  memwb_q, memwb_d;
    logic      pc_src;
    logic      stall;

    ctrl_decoder u_decoder (
        .instr_i (bus.Instruction),
        .ctrl_o  (id_ctrl)
    );

    assign pc_src = Rst ? RESET_PC_SRC : br_taken(idex_q.br_type, bus.ExZero, bus.ExNeg);

`ifdef HAZARD_DETECT_EN
    logic [REG_ADDR_W-1:0] idex_rt_q, idex_rt_d;
    logic [REG_ADDR_W-1:0] id_rs, id_rt;
    logic                  load_use;

    assign id_rs = bus.Instruction[21 +: REG_ADDR_W];
    assign id_rt = bus.Instruction[16 +: REG_ADDR_W];

    assign load_use = idex_q.mem_read && (idex_rt_q != '0) &&
                      ((idex_rt_q == id_rs) ||
                       (reads_rt(bus.Instruction[31:26]) && (idex_rt_q == id_rt)));

    // A taken branch squashes the dependent instruction anyway, so it overrides the stall.
    assign stall = load_use && !pc_src;

    assign idex_rt_d = (pc_src || stall) ? '0 : id_rt;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            idex_rt_q <= '0;
        end else begin
            idex_rt_q <= idex_rt_d;
        end
    end
`else
    assign stall = 1'b0;
`endif

    always_comb begin
        idex_d = (pc_src || stall) ? CTRL_NOP : id_ctrl;

        exmem_d.mem_read   = idex_q.mem_read;
        exmem_d.mem_write  = idex_q.mem_write;
        exmem_d.reg_write  = idex_q.reg_write;
        exmem_d.mem_to_reg = idex_q.mem_to_reg;

        memwb_d.reg_write  = exmem_q.reg_write;
        memwb_d.mem_to_reg = exmem_q.mem_to_reg;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            idex_q  <= CTRL_NOP;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    assign bus.ExRegDst     = idex_q.reg_dst;
    assign bus.ExALUSrc     = idex_q.alu_src;
    assign bus.ExALUControl = ALU_CTRL_W'(idex_q.alu_ctrl);
    assign bus.MemRead      = exmem_q.mem_read;
    assign bus.MemWrite     = exmem_q.mem_write;
    assign bus.WbRegWrite   = memwb_q.reg_write;
    assign bus.WbMemtoReg   = memwb_q.mem_to_reg;
    assign bus.PCSrc        = pc_src;
    assign bus.Stall        = stall;
    assign bus.Flush        = pc_src;

endmodule

// File: tb/tb_pipelined_controller.sv
// Directed-vector bench for pipelined_controller; expectations are hand-derived per instruction
// sequence, with load-use expectations following whether HAZARD_DETECT_EN is defined.
module tb_pipelined_controller;

`ifdef HAZARD_DETECT_EN
    localparam logic HAZ = 1'b1;
`else
    localparam logic HAZ = 1'b0;
`endif

    localparam logic [14:0] OBS_IDLE = 15'h1000;

    localparam logic [31:0] I_ADD     = 32'h00221820;  // add $3,$1,$2
    localparam logic [31:0] I_ADD_RS2 = 32'h00411820;  // add $3,$2,$1
    localparam logic [31:0] I_LW      = 32'h8C220004;  // lw  $2,4($1)
    localparam logic [31:0] I_SW      = 32'hAC220004;  // sw  $2,4($1)
    localparam logic [31:0] I_BNE     = 32'h14220001;
    localparam logic [31:0] I_BEQ     = 32'h10220001;

    typedef struct {
        logic [31:0] instr;
        logic        z;
        logic        n;
        logic        taken;
    } br_vec_t;

    typedef struct {
        logic [31:0] ld;
        logic [31:0] nxt;
        logic        st;
        logic [1:0]  ex;
    } lu_vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    br_vec_t br_tab[8];
    lu_vec_t lu_tab[3];

    pipelined_controller_if #(.ALU_CTRL_W(6)) bus ();

    pipelined_controller #(
        .ALU_CTRL_W   (6),
        .REG_ADDR_W   (5),
        .RESET_PC_SRC (1'b0)
    ) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [14:0] obs;
    assign obs = {bus.ExRegDst, bus.ExALUSrc, bus.ExALUControl, bus.MemRead, bus.MemWrite,
                  bus.WbRegWrite, bus.WbMemtoReg, bus.PCSrc, bus.Stall, bus.Flush};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.Instruction = I_LW;
        bus.ExZero = 1'b0;
        bus.ExNeg  = 1'b0;
        tick();
        tick();
        vectors++;
        if (obs !== OBS_IDLE) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want %h", obs, OBS_IDLE);
        end
    endtask

    task automatic test_add();
        rst = 1'b0;
        bus.Instruction = I_ADD;
        #1;
        vectors++;
        if (obs !== OBS_IDLE) begin
            miscompares++;
            $display("FAIL after_reset: got %h want %h", obs, OBS_IDLE);
        end
        tick();
        bus.Instruction = 32'h0;
        vectors++;
        if ({bus.ExRegDst, bus.ExALUSrc, bus.ExALUControl} !== 8'b10_100000) begin
            miscompares++;
            $display("FAIL add_ex: got %b want %b",
                     {bus.ExRegDst, bus.ExALUSrc, bus.ExALUControl}, 8'b10_100000);
        end
        tick();
        tick();
        vectors++;
        if ({bus.WbRegWrite, bus.WbMemtoReg} !== 2'b10) begin
            miscompares++;
            $display("FAIL add_wb: got %b want 10", {bus.WbRegWrite, bus.WbMemtoReg});
        end
    endtask

    task automatic test_lw_sw();
        bus.Instruction = I_LW;
        tick();
        bus.Instruction = 32'h0;
        tick();
        vectors++;
        if ({bus.MemRead, bus.MemWrite} !== 2'b10) begin
            miscompares++;
            $display("FAIL lw_mem: got %b want 10", {bus.MemRead, bus.MemWrite});
        end
        bus.Instruction = I_SW;
        tick();
        vectors++;
        if ({bus.WbRegWrite, bus.WbMemtoReg} !== 2'b11) begin
            miscompares++;
            $display("FAIL lw_wb: got %b want 11", {bus.WbRegWrite, bus.WbMemtoReg});
        end
        vectors++;
        if ({bus.ExRegDst, bus.ExALUSrc, bus.ExALUControl} !== 8'b01_100000) begin
            miscompares++;
            $display("FAIL sw_ex: got %b want 01100000",
                     {bus.ExRegDst, bus.ExALUSrc, bus.ExALUControl});
        end
        bus.Instruction = 32'h0;
        tick();
        vectors++;
        if ({bus.MemRead, bus.MemWrite} !== 2'b01) begin
            miscompares++;
            $display("FAIL sw_mem: got %b want 01", {bus.MemRead, bus.MemWrite});
        end
        tick();
        vectors++;
        if ({bus.WbRegWrite, bus.WbMemtoReg} !== 2'b00) begin
            miscompares++;
            $display("FAIL sw_wb: got %b want 00", {bus.WbRegWrite, bus.WbMemtoReg});
        end
    endtask

    task automatic test_bne();
        bus.Instruction = I_BNE;
        bus.ExZero = 1'b0;
        tick();
        bus.Instruction = I_ADD;
        #1;
        vectors++;
        if ({bus.PCSrc, bus.Flush, bus.Stall, bus.ExALUControl} !== 9'b110_100010) begin
            miscompares++;
            $display("FAIL bne_taken: got %b want 110100010",
                     {bus.PCSrc, bus.Flush, bus.Stall, bus.ExALUControl});
        end
        tick();
        bus.Instruction = 32'h0;
        #1;
        vectors++;
        if (obs !== OBS_IDLE) begin
            miscompares++;
            $display("FAIL bne_squash: got %h want %h", obs, OBS_IDLE);
        end
        bus.Instruction = I_BNE;
        bus.ExZero = 1'b1;
        tick();
        bus.Instruction = I_ADD;
        #1;
        vectors++;
        if ({bus.PCSrc, bus.Flush} !== 2'b00) begin
            miscompares++;
            $display("FAIL bne_not_taken: got %b want 00", {bus.PCSrc, bus.Flush});
        end
        tick();
        bus.Instruction = 32'h0;
        bus.ExZero = 1'b0;
        vectors++;
        if (bus.ExRegDst !== 1'b1) begin
            miscompares++;
            $display("FAIL bne_fallthru: got %b want 1", bus.ExRegDst);
        end
    endtask

    task automatic test_branch_types();
        br_tab[0] = '{I_BEQ,        1'b1, 1'b0, 1'b1};
        br_tab[1] = '{I_BEQ,        1'b0, 1'b0, 1'b0};
        br_tab[2] = '{32'h1C200001, 1'b0, 1'b0, 1'b1};  // bgtz
        br_tab[3] = '{32'h1C200001, 1'b1, 1'b0, 1'b0};
        br_tab[4] = '{32'h18200001, 1'b0, 1'b1, 1'b1};  // blez
        br_tab[5] = '{32'h04200001, 1'b0, 1'b1, 1'b1};  // bltz
        br_tab[6] = '{32'h04210001, 1'b0, 1'b1, 1'b0};  // bgez
        br_tab[7] = '{32'h04210001, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            bus.Instruction = br_tab[i].instr;
            bus.ExZero = 1'b0;
            bus.ExNeg  = 1'b0;
            tick();
            bus.Instruction = 32'h0;
            bus.ExZero = br_tab[i].z;
            bus.ExNeg  = br_tab[i].n;
            #1;
            vectors++;
            if ({bus.PCSrc, bus.Flush} !== {br_tab[i].taken, br_tab[i].taken}) begin
                miscompares++;
                $display("FAIL branch_%0d: got %b want %b", i, {bus.PCSrc, bus.Flush},
                         {br_tab[i].taken, br_tab[i].taken});
            end
            tick();
        end
        bus.ExZero = 1'b0;
        bus.ExNeg  = 1'b0;
    endtask

    task automatic test_load_use();
        bus.Instruction = I_LW;
        tick();
        bus.Instruction = I_ADD_RS2;
        #1;
        vectors++;
        if ({bus.Stall, bus.Flush} !== {HAZ, 1'b0}) begin
            miscompares++;
            $display("FAIL lu_stall: got %b want %b", {bus.Stall, bus.Flush}, {HAZ, 1'b0});
        end
        tick();
        bus.Instruction = HAZ ? I_ADD_RS2 : 32'h0;
        #1;
        vectors++;
        if ({bus.ExRegDst, bus.Stall, bus.MemRead} !== {~HAZ, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL lu_bubble: got %b want %b",
                     {bus.ExRegDst, bus.Stall, bus.MemRead}, {~HAZ, 1'b0, 1'b1});
        end
        tick();
        bus.Instruction = 32'h0;
        vectors++;
        if (bus.ExRegDst !== HAZ) begin
            miscompares++;
            $display("FAIL lu_resume: got %b want %b", bus.ExRegDst, HAZ);
        end

        lu_tab[0] = '{I_LW,         I_ADD,        HAZ,  HAZ ? 2'b00 : 2'b10};
        lu_tab[1] = '{I_LW,         32'h20220005, 1'b0, 2'b01};  // addi writes rt
        lu_tab[2] = '{32'h8C200004, 32'h00011820, 1'b0, 2'b10};  // lw to $0
        for (int i = 0; i < 3; i++) begin
            bus.Instruction = lu_tab[i].ld;
            tick();
            bus.Instruction = lu_tab[i].nxt;
            #1;
            vectors++;
            if (bus.Stall !== lu_tab[i].st) begin
                miscompares++;
                $display("FAIL lu_case_%0d_stall: got %b want %b", i, bus.Stall, lu_tab[i].st);
            end
            tick();
            bus.Instruction = 32'h0;
            vectors++;
            if ({bus.ExRegDst, bus.ExALUSrc} !== lu_tab[i].ex) begin
                miscompares++;
                $display("FAIL lu_case_%0d_ex: got %b want %b", i,
                         {bus.ExRegDst, bus.ExALUSrc}, lu_tab[i].ex);
            end
            tick();
        end
    endtask

    task automatic test_branch_priority();
        bus.Instruction = I_BEQ;
        bus.ExZero = 1'b0;
        tick();
        bus.Instruction = I_ADD_RS2;
        bus.ExZero = 1'b1;
        #1;
        vectors++;
        if ({bus.PCSrc, bus.Stall, bus.Flush} !== 3'b101) begin
            miscompares++;
            $display("FAIL prio_flush: got %b want 101", {bus.PCSrc, bus.Stall, bus.Flush});
        end
        tick();
        bus.Instruction = 32'h0;
        bus.ExZero = 1'b0;
        vectors++;
        if (bus.ExRegDst !== 1'b0) begin
            miscompares++;
            $display("FAIL prio_squash: got %b want 0", bus.ExRegDst);
        end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        bus.Instruction = I_LW;
        tick();
        bus.Instruction = I_ADD_RS2;
        #1;
        vectors++;
        if (bus.Stall !== HAZ) begin
            miscompares++;
            $display("FAIL rst_pre_stall: got %b want %b", bus.Stall, HAZ);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if (obs !== OBS_IDLE) begin
            miscompares++;
            $display("FAIL rst_mid_stall: got %h want %h", obs, OBS_IDLE);
        end
        rst = 1'b0;
        bus.Instruction = 32'h0;
        tick();
    endtask

    initial begin
        bus.Instruction = 32'h0;
        bus.ExZero = 1'b0;
        bus.ExNeg  = 1'b0;
        test_reset();
        test_add();
        test_lw_sw();
        test_bne();
        test_branch_types();
        test_load_use();
        test_branch_priority();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
